// File: rtl/booth_mac_ctrl.sv
// Multiply-accumulate sequencer that feeds a 12x12 radix-4 Booth multiplier and sums its products.
// Defining MAC_SATURATE_EN clamps the accumulator on overflow; otherwise it wraps modulo 2^ACC_W.
module booth_mac_ctrl #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [11:0]      in_a,
  input  logic signed [11:0]      in_b,
  input  logic                    in_last,
  output logic                    mult_start,
  output logic signed [11:0]      mult_a,
  output logic signed [11:0]      mult_b,
  input  logic                    mult_ready,
  input  logic signed [23:0]      mult_prod,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0]        out_count,
  output logic                    out_ovf
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    ovf_q, ovf_d;
  logic signed [11:0]      a_q, a_d, b_q, b_d;
  logic                    last_q, last_d;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;

  // Signed overflow: both addends share a sign that the sum does not.
  function automatic logic ovf_detect(input logic signed [ACC_W-1:0] x,
                                      input logic signed [ACC_W-1:0] y,
                                      input logic signed [ACC_W-1:0] s);
    return (x[ACC_W-1] == y[ACC_W-1]) && (s[ACC_W-1] != x[ACC_W-1]);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_clamp(input logic neg);
    return neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign prod_ext = ACC_W'(mult_prod);
  assign sum      = acc_q + prod_ext;
  assign add_ovf  = ovf_detect(acc_q, prod_ext, sum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    a_d        = a_q;
    b_d        = b_q;
    last_d     = last_q;
    in_ready   = 1'b0;
    mult_start = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          last_d  = in_last;
          state_d = START;
        end
      end
      START: begin
        mult_start = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        // Ready is guaranteed low on the first WAIT cycle, so its first high marks the new product.
        if (mult_ready) begin
`ifdef MAC_SATURATE_EN
          acc_d = add_ovf ? sat_clamp(prod_ext[ACC_W-1]) : sum;
`else
          acc_d = sum;
`endif
          ovf_d   = ovf_q | add_ovf;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mult_a    = a_q;
  assign mult_b    = b_q;
  assign out_acc   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Directed bench for booth_mac_ctrl with a behavioural 6-iteration Booth multiplier model.
// Expected saturation/wrap result follows MAC_SATURATE_EN, the same macro the design uses.
module tb_booth_mac_ctrl;

  localparam int ACC_W = 32;
  localparam int CNT_W = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [11:0]      in_a;
  logic signed [11:0]      in_b;
  logic                    in_last;
  logic                    mult_start;
  logic signed [11:0]      mult_a;
  logic signed [11:0]      mult_b;
  logic                    mult_ready;
  logic signed [23:0]      mult_prod;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0]        out_count;
  logic                    out_ovf;

  int n_chk  = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  int st_cnt = 0;

  booth_mac_ctrl #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_ready(mult_ready), .mult_prod(mult_prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Multiplier model: idle/ready until a start, then busy for 6 cycles with the product held.
  logic [2:0] m_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy    <= '0;
      mult_prod <= '0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 3'd1;
    end else if (mult_start) begin
      m_busy    <= 3'd6;
      mult_prod <= mult_a * mult_b;
    end
  end
  assign mult_ready = (m_busy == 0);

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
      if (mult_start)           st_cnt <= st_cnt + 1;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [11:0] a, input logic signed [11:0] b, input logic last);
    int t = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic get_result(output longint acc, output longint cnt, output longint ovf,
                            output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    if (lat >= 200) check("out_valid_timeout", 0, 1);
    acc = out_acc; cnt = out_count; ovf = out_ovf;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc, cnt, ovf, acc0;
    int lat, gap, bad, st0, hs0;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready",   in_ready, 1);
    check("rst_out_valid",  out_valid, 0);
    check("rst_mult_start", mult_start, 0);
    check("rst_out_acc",    out_acc, 0);
    rst = 1'b0;
    tick();

    // Test 1: (3,4),(-5,6,last) = -18
    send(12'sd3, 12'sd4, 1'b0);
    gap = 0;
    while (!in_ready && gap < 50) begin
      gap++;
      tick();
    end
    check("in_ready_gap", gap, 8);
    send(-12'sd5, 12'sd6, 1'b1);
    get_result(acc, cnt, ovf, lat);
    check("t1_latency", lat, 8);
    check("t1_acc", acc, -18);
    check("t1_count", cnt, 2);
    check("t1_ovf", ovf, 0);

    // Test 2: extreme single products
    send(-12'sd2048, -12'sd2048, 1'b1);
    get_result(acc, cnt, ovf, lat);
    check("t2a_acc", acc, 4194304);
    check("t2a_count", cnt, 1);
    send(-12'sd2048, 12'sd2047, 1'b1);
    get_result(acc, cnt, ovf, lat);
    check("t2b_acc", acc, -4192256);
    check("t2b_ovf", ovf, 0);

    // Test 3: 512 x 2^22 = 2^31 overflows on the last term
    for (int i = 0; i < 512; i++) send(-12'sd2048, -12'sd2048, i == 511);
    get_result(acc, cnt, ovf, lat);
    check("t3_count", cnt, 512);
    check("t3_ovf", ovf, 1);
`ifdef MAC_SATURATE_EN
    check("t3_acc", acc, 64'sd2147483647);
`else
    check("t3_acc", acc, -64'sd2147483648);
`endif

    // Test 4: stall in DONE for 20 cycles
    send(12'sd7, -12'sd3, 1'b1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    acc0 = out_acc;
    check("t4_acc", acc0, -21);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_acc !== acc0 || in_ready !== 1'b0) bad++;
    end
    check("t4_hold_unstable_cycles", bad, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    send(12'sd1, 12'sd1, 1'b1);
    get_result(acc, cnt, ovf, lat);
    check("t4_next_acc", acc, 1);
    check("t4_next_count", cnt, 1);

    // Test 5: reset during WAIT of the second term
    send(12'sd10, 12'sd10, 1'b0);
    send(12'sd20, 12'sd20, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("t5_in_ready",   in_ready, 1);
    check("t5_out_valid",  out_valid, 0);
    check("t5_mult_start", mult_start, 0);
    check("t5_mult_a",     mult_a, 0);
    check("t5_mult_b",     mult_b, 0);
    check("t5_out_acc",    out_acc, 0);
    check("t5_out_count",  out_count, 0);
    check("t5_out_ovf",    out_ovf, 0);
    rst = 1'b0;
    tick();
    send(12'sd2, 12'sd3, 1'b1);
    get_result(acc, cnt, ovf, lat);
    check("t5_acc", acc, 6);
    check("t5_count", cnt, 1);

    // Test 6: in_valid toggling while busy
    st0 = st_cnt; hs0 = hs_cnt;
    send(12'sd4, 12'sd5, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      in_a = 12'(i * 37); in_b = -12'(i + 9); in_last = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("t6_mult_a_held", mult_a, 4);
    check("t6_mult_b_held", mult_b, 5);
    send(12'sd1, 12'sd2, 1'b1);
    get_result(acc, cnt, ovf, lat);
    check("t6_acc", acc, 22);
    check("t6_count", cnt, 2);
    check("t6_starts", st_cnt - st0, 2);
    check("t6_handshakes", hs_cnt - hs0, 2);
    check("starts_vs_pairs", st_cnt, hs_cnt);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
